// File: rtl/mips_pkg.sv
// Shared encodings and default vectors for the multicycle MIPS datapath.
// Imported by the PC unit and its next-PC mux.
package mips_pkg;

    localparam int unsigned DEF_WIDTH        = 32;
    localparam int unsigned DEF_ALIGN_BITS   = 2;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JUMP   = 2'd2,
        PCSRC_EPC    = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        EXC  = 2'd2
    } pc_state_t;

    // A branch write only counts when the ALU compare agrees.
    function automatic logic pc_write_req(input logic write,
                                          input logic write_cond,
                                          input logic taken);
        return write | (write_cond & taken);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC source select plus target alignment check. Purely combinational.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  logic [1:0]       i_pc_src,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic [WIDTH-1:0] i_jump_target,
    input  logic [WIDTH-1:0] i_epc,
    output logic [WIDTH-1:0] o_next,
    output logic             o_misaligned
);

    // Mask of low bits that must be zero; all-zero when ALIGN_BITS is 0.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~({WIDTH{1'b1}} << ALIGN_BITS);

    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = i_alu_result;
        case (pc_src_t'(i_pc_src))
            PCSRC_ALU:    w_next = i_alu_result;
            PCSRC_ALUOUT: w_next = i_alu_out;
            PCSRC_JUMP:   w_next = i_jump_target;
            PCSRC_EPC:    w_next = i_epc;
            default:      w_next = i_alu_result;
        endcase
    end

    assign o_next       = w_next;
    assign o_misaligned = |(w_next & ALIGN_MASK);

endmodule

// File: rtl/pc_unit.sv
// Program counter with internal next-PC select, branch-qualified writes,
// exception entry/return and misaligned-target trapping.
module pc_unit
    import mips_pkg::*;
#(
    parameter int unsigned      WIDTH        = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int unsigned      ALIGN_BITS   = DEF_ALIGN_BITS
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_pc_write,
    input  logic             i_pc_write_cond,
    input  logic             i_branch_taken,
    input  logic [1:0]       i_pc_src,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic [WIDTH-1:0] i_jump_target,
    input  logic             i_exc_req,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_epc,
    output logic [WIDTH-1:0] o_bad_addr,
    output logic             o_pc_valid,
    output logic             o_exc_ack,
    output logic             o_misaligned,
    output logic             o_in_exc,
    output logic [1:0]       o_state
);

    pc_state_t        r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [WIDTH-1:0] r_bad_addr;
    logic             r_exc_ack;
    logic             r_misaligned;

    pc_state_t        w_state_nxt;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_epc_nxt;
    logic [WIDTH-1:0] w_bad_addr_nxt;
    logic             w_exc_ack_nxt;
    logic             w_misaligned_nxt;

    logic             w_write;
    logic [WIDTH-1:0] w_next;
    logic             w_next_bad;
    logic             w_is_eret;

    pc_next_mux #(
        .WIDTH      (WIDTH),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_next_mux (
        .i_pc_src      (i_pc_src),
        .i_alu_result  (i_alu_result),
        .i_alu_out     (i_alu_out),
        .i_jump_target (i_jump_target),
        .i_epc         (r_epc),
        .o_next        (w_next),
        .o_misaligned  (w_next_bad)
    );

    assign w_write   = pc_write_req(i_pc_write, i_pc_write_cond, i_branch_taken);
    assign w_is_eret = (pc_src_t'(i_pc_src) == PCSRC_EPC);

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_epc_nxt        = r_epc;
        w_bad_addr_nxt   = r_bad_addr;
        w_exc_ack_nxt    = 1'b0;
        w_misaligned_nxt = 1'b0;

        if (i_enable) begin
            case (r_state)
                BOOT: w_state_nxt = RUN;

                RUN: begin
                    if (i_exc_req || (w_write && w_next_bad)) begin
                        // A rejected target still records what was attempted.
                        if (!i_exc_req) begin
                            w_bad_addr_nxt   = w_next;
                            w_misaligned_nxt = 1'b1;
                        end
                        w_epc_nxt     = r_pc;
                        w_pc_nxt      = EXC_VECTOR;
                        w_exc_ack_nxt = 1'b1;
                        w_state_nxt   = EXC;
                    end else if (w_write) begin
                        w_pc_nxt = w_next;
                    end
                end

                EXC: begin
                    // No nesting: exc_req is ignored and a bad target only reports.
                    if (w_write && w_next_bad) begin
                        w_bad_addr_nxt   = w_next;
                        w_misaligned_nxt = 1'b1;
                    end else if (w_write) begin
                        w_pc_nxt = w_next;
                        if (w_is_eret) begin
                            w_state_nxt = RUN;
                        end
                    end
                end

                default: w_state_nxt = BOOT;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= BOOT;
            r_pc         <= RESET_VECTOR;
            r_epc        <= '0;
            r_bad_addr   <= '0;
            r_exc_ack    <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_epc        <= w_epc_nxt;
            r_bad_addr   <= w_bad_addr_nxt;
            r_exc_ack    <= w_exc_ack_nxt;
            r_misaligned <= w_misaligned_nxt;
        end
    end

    assign o_pc         = r_pc;
    assign o_epc        = r_epc;
    assign o_bad_addr   = r_bad_addr;
    assign o_exc_ack    = r_exc_ack;
    assign o_misaligned = r_misaligned;
    assign o_pc_valid   = (r_state != BOOT);
    assign o_in_exc     = (r_state == EXC);
    assign o_state      = r_state;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the plain PC register of the multicycle MIPS datapath.
- Holds the PC and selects the next-PC source internally.
- Handles branch-conditional writes and exception entry/return (EPC capture, vector redirect).
- Detects misaligned targets and reports them.
- Sits between the control FSM/ALU and the memory-address mux.

Parameters:
- WIDTH, 32, PC/EPC/data width.
- RESET_VECTOR, 32'h00400000, PC value loaded on reset.
- EXC_VECTOR, 32'h80000180, PC value loaded on exception entry.
- ALIGN_BITS, 2, number of low target bits that must be zero (0 disables the check).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  global stall; low freezes all state.
- pc_write  input  1  unconditional PC write.
- pc_write_cond  input  1  branch write, qualified by branch_taken.
- branch_taken  input  1  ALU zero/compare result.
- pc_src  input  2  next-PC select: 0 alu_result, 1 alu_out, 2 jump_target, 3 epc (eret).
- alu_result  input  WIDTH  combinational ALU output (PC+4).
- alu_out  input  WIDTH  registered ALU output (branch target).
- jump_target  input  WIDTH  pre-formed jump address.
- exc_req  input  1  external exception request (overflow, illegal op).
- pc  output  WIDTH  current PC.
- epc  output  WIDTH  exception PC.
- bad_addr  output  WIDTH  last misaligned target.
- pc_valid  output  1  high when PC may be used for fetch.
- exc_ack  output  1  one-cycle pulse on exception entry.
- misaligned  output  1  one-cycle pulse when a misaligned target is rejected.
- in_exc  output  1  high while in exception state.

Behaviour:
- Reset (asynchronous, any time, including mid-exception):
  - pc=RESET_VECTOR; epc=0; bad_addr=0.
  - pc_valid=0, exc_ack=0, misaligned=0, in_exc=0.
  - state=BOOT.
- FSM states: BOOT, RUN, EXC.
- BOOT → RUN on the first enabled clock after reset deasserts. pc_valid is 0 in BOOT and 1 in RUN and EXC. All writes and exc_req are ignored in BOOT.
- enable=0: every register, including the state, holds. Pulse outputs go 0 for that cycle.
- write = pc_write | (pc_write_cond & branch_taken).
- next = mux(pc_src); evaluated only when write=1.
- Priority per enabled clock in RUN: exc_req > misaligned write > normal write > hold.
  - exc_req=1 in RUN: epc<=pc; pc<=EXC_VECTOR; exc_ack=1 for 1 cycle; state→EXC. Any simultaneous write is discarded.
  - Misaligned write (ALIGN_BITS>0 and next[ALIGN_BITS-1:0]!=0): pc is not loaded with next. Instead bad_addr<=next; misaligned=1 for 1 cycle; then the exception-entry action runs (epc<=pc, pc<=EXC_VECTOR, exc_ack=1, state→EXC).
  - Normal write: pc<=next, with 1-cycle latency.
- In EXC:
  - exc_req is ignored (no nesting).
  - Writes with pc_src 0–2 behave as in RUN. A misaligned write in EXC sets bad_addr and misaligned, but does not redirect and pc holds.
  - Write with pc_src=3 (eret): pc<=epc; state→RUN. The same alignment check applies.
- pc_src=3 in RUN is a legal plain load of epc; the state is unchanged.
- All arithmetic lives outside this block; there is no wrap logic. Values are WIDTH-bit and truncated or zero-extended when assigned.
- Outputs are registered; pulse outputs are high exactly one enabled cycle.

Decomposition:
- Shared package mips_pkg holds:
  - pc_src encodings (PCSRC_ALU=0, PCSRC_ALUOUT=1, PCSRC_JUMP=2, PCSRC_EPC=3).
  - State encodings (BOOT, RUN, EXC).
  - Default vectors.
- One sub-module: pc_next_mux (4:1 WIDTH mux plus alignment check), combinational.
- The FSM and registers live in pc_unit.

Test Plan:
- Reset then release, enable=1:
  - pc=32'h00400000 and pc_valid=0 in the first cycle.
  - pc_valid=1 on the next edge.
- RUN, pc_write=1, pc_src=0, alu_result=32'h00400004 → pc=32'h00400004 one edge later.
- Branch write:
  - pc_write_cond=1, branch_taken=0, alu_out=32'h00400040 → pc holds.
  - Same with branch_taken=1 → pc=32'h00400040.
- Exception with simultaneous write:
  - Inputs: pc=32'h00400010, exc_req=1 and pc_write=1.
  - Expected: epc=32'h00400010, pc=32'h80000180, exc_ack pulse, in_exc=1.
  - Then eret (pc_write=1, pc_src=3) → pc=32'h00400010, in_exc=0.
- Misaligned jump:
  - Inputs: RUN, pc_write=1, pc_src=2, jump_target=32'h00400006.
  - Expected: bad_addr=32'h00400006, misaligned pulse, epc=old pc, pc=32'h80000180.
- Stall and reset:
  - enable=0 with pc_write=1 and exc_req=1 for 3 cycles → pc, epc and state unchanged.
  - Assert reset mid-EXC between clock edges → pc=32'h00400000 and in_exc=0 immediately.
